// File: rtl/fifo_rd_packer.sv
// Read-side byte packer: pops a show-ahead byte FIFO and assembles little-endian words behind a double buffer.
// Optional FIFO_RD_PACKER_PARITY_EN adds a per-lane even-parity output registered with the word.
module fifo_rd_packer #(
  parameter int BYTES   = 4,
  parameter int TIMEOUT = 0
) (
  input  logic               rclk,
  input  logic               rrst_n,
  input  logic [7:0]         rdata,
  input  logic               rempty,
  output logic               rinc,
  input  logic               flush,
  output logic [8*BYTES-1:0] out_data,
  output logic [BYTES-1:0]   out_be,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_last,
`ifdef FIFO_RD_PACKER_PARITY_EN
  output logic [BYTES-1:0]   out_parity,
`endif
  output logic               busy
);

  localparam int LW = $clog2(BYTES + 1);
  localparam int IW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [LW-1:0] LANE_FULL  = LW'(BYTES);
  localparam logic [LW-1:0] LANE_LAST  = LW'(BYTES - 1);
  localparam logic [IW-1:0] IDLE_LIMIT = IW'(TIMEOUT);

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [8*BYTES-1:0] pk_q, pk_d, pkIns;
  logic [LW-1:0]      lane_q, lane_d;
  logic [IW-1:0]      idle_q, idle_d;
  logic               flushPend_q, flushPend_d;
  logic               flushReq_q, flushReq_d;
  logic [8*BYTES-1:0] outData_q, outData_d;
  logic [BYTES-1:0]   outBe_q, outBe_d;
  logic               outValid_q, outValid_d;
  logic               outLast_q, outLast_d;
  logic [BYTES-1:0]   partialBe;

  logic outFree;
  logic doFull;
  logic doPartial;
  logic doDrop;
  logic timeoutFire;

  assign outFree = !outValid_q || out_ready;

  // State register.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      state_q <= FILL;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state follows the pending-flush flag first, then whether the pack register is full.
  always_comb begin
    state_d = FILL;
    if (flushPend_d) begin
      state_d = FLUSH;
    end else if (lane_d == LANE_FULL) begin
      state_d = STALL;
    end
  end

  // Control outputs: pop strobe and which kind of output-register load happens this edge.
  always_comb begin
    rinc      = 1'b0;
    doFull    = 1'b0;
    doPartial = 1'b0;
    doDrop    = 1'b0;
    unique case (state_q)
      FILL: begin
        rinc   = rrst_n && !rempty;
        doFull = outFree && rinc && (lane_q == LANE_LAST);
      end
      STALL: begin
        doFull = outFree;
      end
      FLUSH: begin
        if (outFree) begin
          if (lane_q == LANE_FULL) begin
            doFull = 1'b1;
          end else if (lane_q != '0) begin
            doPartial = 1'b1;
          end else begin
            doDrop = 1'b1;
          end
        end
      end
      default: begin
      end
    endcase
  end

  always_comb begin
    pkIns = pk_q;
    for (int i = 0; i < BYTES; i++) begin
      if (rinc && (lane_q == LW'(i))) begin
        pkIns[8*i +: 8] = rdata;
      end
    end
  end

  always_comb begin
    partialBe = '0;
    for (int i = 0; i < BYTES; i++) begin
      partialBe[i] = (LW'(i) < lane_q);
    end
  end

  // Idle counter only advances while filling a partial word with nothing arriving.
  always_comb begin
    idle_d      = '0;
    timeoutFire = 1'b0;
    if ((state_q == FILL) && !rinc && (lane_q != '0)) begin
      idle_d      = idle_q + 1'b1;
      timeoutFire = (TIMEOUT > 0) && (idle_d == IDLE_LIMIT);
    end
  end

  always_comb begin
    lane_d = lane_q;
    pk_d   = pkIns;
    if (doFull || doPartial) begin
      lane_d = '0;
      pk_d   = '0;
    end else if (rinc) begin
      lane_d = lane_q + 1'b1;
    end
    flushPend_d = (flushPend_q && !(doPartial || doDrop)) || flush || timeoutFire;
    flushReq_d  = (flushReq_q && !(doPartial || doDrop)) || flush;
  end

  // Output register holds its word until accepted; a full word carries the byte popped this edge.
  always_comb begin
    outData_d  = outData_q;
    outBe_d    = outBe_q;
    outLast_d  = outLast_q;
    outValid_d = outValid_q && !out_ready;
    if (doFull) begin
      outData_d  = pkIns;
      outBe_d    = '1;
      outLast_d  = 1'b0;
      outValid_d = 1'b1;
    end else if (doPartial) begin
      outData_d  = pk_q;
      outBe_d    = partialBe;
      outLast_d  = flushReq_q;
      outValid_d = 1'b1;
    end
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      pk_q        <= '0;
      lane_q      <= '0;
      idle_q      <= '0;
      flushPend_q <= 1'b0;
      flushReq_q  <= 1'b0;
      outData_q   <= '0;
      outBe_q     <= '0;
      outValid_q  <= 1'b0;
      outLast_q   <= 1'b0;
    end else begin
      pk_q        <= pk_d;
      lane_q      <= lane_d;
      idle_q      <= idle_d;
      flushPend_q <= flushPend_d;
      flushReq_q  <= flushReq_d;
      outData_q   <= outData_d;
      outBe_q     <= outBe_d;
      outValid_q  <= outValid_d;
      outLast_q   <= outLast_d;
    end
  end

`ifdef FIFO_RD_PACKER_PARITY_EN
  logic [BYTES-1:0] parity_q, parity_d;

  always_comb begin
    parity_d = '0;
    for (int i = 0; i < BYTES; i++) begin
      parity_d[i] = outBe_d[i] & (^outData_d[8*i +: 8]);
    end
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      parity_q <= '0;
    end else begin
      parity_q <= parity_d;
    end
  end

  assign out_parity = parity_q;
`endif

  assign out_data  = outData_q;
  assign out_be    = outBe_q;
  assign out_valid = outValid_q;
  assign out_last  = outLast_q;
  assign busy      = (lane_q != '0) || outValid_q || flushPend_q;

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Directed scoreboard bench for fifo_rd_packer (BYTES=4, TIMEOUT=5) with a show-ahead FIFO model.
// Honours FIFO_RD_PACKER_PARITY_EN by checking out_parity against the expected word.
module tb_fifo_rd_packer;

  localparam int BYTES   = 4;
  localparam int TIMEOUT = 5;

  logic        rclk      = 1'b0;
  logic        rrst_n    = 1'b0;
  logic [7:0]  rdata     = 8'h00;
  logic        rempty    = 1'b1;
  logic        rinc;
  logic        flush     = 1'b0;
  logic [31:0] out_data;
  logic [3:0]  out_be;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        out_last;
  logic        busy;
`ifdef FIFO_RD_PACKER_PARITY_EN
  logic [3:0]  out_parity;
`endif

  typedef struct {
    logic [31:0] data;
    logic [3:0]  be;
    logic        last;
  } expT;

  logic [7:0] fifoQ[$];
  expT        expQ[$];
  int         popCyc[$];
  int         accCyc[$];
  int         cyc      = 0;
  int         checks   = 0;
  int         failures = 0;
  int         markCyc  = 0;

  fifo_rd_packer #(.BYTES(BYTES), .TIMEOUT(TIMEOUT)) dut (
    .rclk      (rclk),
    .rrst_n    (rrst_n),
    .rdata     (rdata),
    .rempty    (rempty),
    .rinc      (rinc),
    .flush     (flush),
    .out_data  (out_data),
    .out_be    (out_be),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
`ifdef FIFO_RD_PACKER_PARITY_EN
    .out_parity(out_parity),
`endif
    .busy      (busy)
  );

  always #5 rclk = ~rclk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic updatePins();
    rempty = (fifoQ.size() == 0);
    rdata  = rempty ? 8'h00 : fifoQ[0];
  endtask

  task automatic pushByte(input logic [7:0] b);
    fifoQ.push_back(b);
    updatePins();
  endtask

  task automatic expectWord(input logic [31:0] d, input logic [3:0] be, input logic last);
    expT e;
    e.data = d;
    e.be   = be;
    e.last = last;
    expQ.push_back(e);
  endtask

  task automatic scoreWord();
    expT e;
    if (expQ.size() == 0) begin
      checkOutput("unexpected_word", 64'(out_data), 64'hDEAD_0000);
    end else begin
      e = expQ.pop_front();
      checkOutput("word_data", 64'(out_data), 64'(e.data));
      checkOutput("word_be", 64'(out_be), 64'(e.be));
      checkOutput("word_last", 64'(out_last), 64'(e.last));
`ifdef FIFO_RD_PACKER_PARITY_EN
      begin
        logic [3:0] parExp;
        for (int i = 0; i < BYTES; i++) begin
          parExp[i] = e.be[i] & (^e.data[8*i +: 8]);
        end
        checkOutput("word_parity", 64'(out_parity), 64'(parExp));
      end
`endif
    end
  endtask

  // One clock: drive inputs, sample at the falling edge, then advance the FIFO model after the rising edge.
  task automatic applyStimulus(input logic fl, input logic rdy);
    logic       popNow;
    logic [7:0] dropped;
    flush     = fl;
    out_ready = rdy;
    @(negedge rclk);
    popNow = (rinc === 1'b1) && !rempty;
    if ((out_valid === 1'b1) && out_ready) begin
      accCyc.push_back(cyc);
      scoreWord();
    end
    if (popNow) popCyc.push_back(cyc);
    @(posedge rclk);
    #1;
    if (popNow) dropped = fifoQ.pop_front();
    updatePins();
    flush = 1'b0;
    cyc++;
  endtask

  task automatic drain(input int maxCyc);
    for (int i = 0; i < maxCyc; i++) begin
      if (expQ.size() == 0) break;
      applyStimulus(1'b0, 1'b1);
    end
    checkOutput("drain_pending", 64'(expQ.size()), 64'd0);
  endtask

  initial begin
    updatePins();

    // Reset with bytes already waiting: nothing may pop and every output is zero.
    for (int i = 1; i <= 8; i++) pushByte(8'(i));
    expectWord(32'h0403_0201, 4'hF, 1'b0);
    expectWord(32'h0807_0605, 4'hF, 1'b0);
    repeat (2) @(posedge rclk);
    #1;
    checkOutput("reset_rinc", 64'(rinc), 64'd0);
    checkOutput("reset_valid", 64'(out_valid), 64'd0);
    checkOutput("reset_last", 64'(out_last), 64'd0);
    checkOutput("reset_busy", 64'(busy), 64'd0);
    checkOutput("reset_data", 64'(out_data), 64'd0);
    checkOutput("reset_be", 64'(out_be), 64'd0);
    rrst_n = 1'b1;

    $display("[TB] two full words at byte rate");
    popCyc.delete();
    accCyc.delete();
    repeat (10) applyStimulus(1'b0, 1'b1);
    checkOutput("rate_pops", 64'(popCyc.size()), 64'd8);
    checkOutput("rate_pop_span", 64'(popCyc[7] - popCyc[0]), 64'd7);
    checkOutput("rate_words", 64'(accCyc.size()), 64'd2);
    checkOutput("rate_latency", 64'(accCyc[0] - popCyc[3]), 64'd1);
    checkOutput("rate_spacing", 64'(accCyc[1] - accCyc[0]), 64'(BYTES));
    checkOutput("rate_pending", 64'(expQ.size()), 64'd0);

    $display("[TB] explicit flush of three bytes");
    pushByte(8'hAA);
    pushByte(8'hBB);
    pushByte(8'hCC);
    expectWord(32'h00CC_BBAA, 4'h7, 1'b1);
    accCyc.delete();
    repeat (4) applyStimulus(1'b0, 1'b1);
    checkOutput("flush_busy_before", 64'(busy), 64'd1);
    markCyc = cyc;
    applyStimulus(1'b1, 1'b1);
    drain(10);
    checkOutput("flush_latency", 64'(accCyc[0] - markCyc), 64'd2);
    checkOutput("flush_busy_after", 64'(busy), 64'd0);

    $display("[TB] sink stalled with twelve bytes queued");
    for (int i = 0; i < 12; i++) pushByte(8'(8'h30 + i));
    expectWord(32'h3332_3130, 4'hF, 1'b0);
    expectWord(32'h3736_3534, 4'hF, 1'b0);
    expectWord(32'h3B3A_3938, 4'hF, 1'b0);
    popCyc.delete();
    repeat (12) applyStimulus(1'b0, 1'b0);
    checkOutput("stall_pops", 64'(popCyc.size()), 64'd8);
    checkOutput("stall_fifo_left", 64'(fifoQ.size()), 64'd4);
    checkOutput("stall_rinc", 64'(rinc), 64'd0);
    checkOutput("stall_valid", 64'(out_valid), 64'd1);
    checkOutput("stall_data_held", 64'(out_data), 64'h3332_3130);
    drain(30);
    checkOutput("stall_fifo_empty", 64'(fifoQ.size()), 64'd0);

    // Five idle edges raise the pending flush; the partial word loads on the next edge.
    $display("[TB] idle timeout on a single byte");
    pushByte(8'h5A);
    expectWord(32'h0000_005A, 4'h1, 1'b0);
    popCyc.delete();
    accCyc.delete();
    drain(20);
    checkOutput("timeout_latency", 64'(accCyc[0] - popCyc[0]), 64'(TIMEOUT + 2));

    $display("[TB] flush together with the second pop");
    pushByte(8'h11);
    pushByte(8'h22);
    pushByte(8'h33);
    expectWord(32'h0000_2211, 4'h3, 1'b1);
    expectWord(32'h0000_0033, 4'h1, 1'b0);
    popCyc.delete();
    accCyc.delete();
    applyStimulus(1'b0, 1'b1);
    markCyc = cyc;
    applyStimulus(1'b1, 1'b1);
    checkOutput("flush_pend_rinc", 64'(rinc), 64'd0);
    checkOutput("flush_pend_pops", 64'(popCyc.size()), 64'd2);
    drain(30);
    checkOutput("flush_same_latency", 64'(accCyc[0] - markCyc), 64'd2);

    $display("[TB] reset in the middle of a word");
    pushByte(8'h21);
    pushByte(8'h43);
    repeat (2) applyStimulus(1'b0, 1'b1);
    checkOutput("midword_busy", 64'(busy), 64'd1);
    pushByte(8'h0A);
    pushByte(8'h0B);
    pushByte(8'h0C);
    pushByte(8'h0D);
    pushByte(8'h0B);
    pushByte(8'h0E);
    pushByte(8'h01);
    pushByte(8'h07);
    rrst_n = 1'b0;
    #1;
    checkOutput("midreset_rinc", 64'(rinc), 64'd0);
    checkOutput("midreset_valid", 64'(out_valid), 64'd0);
    checkOutput("midreset_data", 64'(out_data), 64'd0);
    checkOutput("midreset_be", 64'(out_be), 64'd0);
    checkOutput("midreset_last", 64'(out_last), 64'd0);
    checkOutput("midreset_busy", 64'(busy), 64'd0);
    expectWord(32'h0D0C_0B0A, 4'hF, 1'b0);
    expectWord(32'h0701_0E0B, 4'hF, 1'b0);
    @(posedge rclk);
    #1;
    rrst_n = 1'b1;
    drain(30);
    checkOutput("postreset_fifo_empty", 64'(fifoQ.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
